// File: rtl/game_flow_controller.sv
// Top-level game sequencer: title, countdown, play, bonus tally,
// death and game-over screens, plus per-level second timer.
//
// Ports:
//   clk, rst           system clock, async active-high reset
//   frame_tick         one-cycle pulse per video frame
//   start              start button (level-sensitive, IDLE only)
//   level[3:0]         current level from level management
//   level_done         pulse: heroes reached the goal
//   hero_caught        pulse: hero hit by an enemy
//   game_state[2:0]    IDLE=0 READY=1 PLAY=2 CLEAR=3 DYING=4 OVER=5
//   play_en            high only in PLAY
//   lives[1:0]         remaining lives
//   time_left[7:0]     remaining seconds in the level
//   bonus_valid        pulse: add bonus_value to score
//   bonus_value[15:0]  constant bonus per remaining second
//   game_rst           pulse: reset score/level units
//   hero_rst_req       pulse: return heroes/enemies to start

module game_flow_controller #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int LEVEL_TIME     = 120,
  parameter int TIME_STEP      = 4,
  parameter int MIN_TIME       = 40,
  parameter int READY_FRAMES   = 120,
  parameter int DEATH_FRAMES   = 90,
  parameter int OVER_FRAMES    = 240,
  parameter int START_LIVES    = 3,
  parameter int BONUS_PER_SEC  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [3:0]  level,
  input  logic        level_done,
  input  logic        hero_caught,
  output logic [2:0]  game_state,
  output logic        play_en,
  output logic [1:0]  lives,
  output logic [7:0]  time_left,
  output logic        bonus_valid,
  output logic [15:0] bonus_value,
  output logic        game_rst,
  output logic        hero_rst_req
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_CLEAR = 3'd3,
    S_DYING = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [15:0] FPS_M1 = 16'(FRAMES_PER_SEC - 1);
  localparam logic [15:0] RDY_M1 = 16'(READY_FRAMES - 1);
  localparam logic [15:0] DTH_M1 = 16'(DEATH_FRAMES - 1);
  localparam logic [15:0] OVR_M1 = 16'(OVER_FRAMES - 1);

  localparam logic [8:0] LT9 = 9'(LEVEL_TIME);
  localparam logic [8:0] TS9 = 9'(TIME_STEP);
  localparam logic [8:0] MT9 = 9'(MIN_TIME);

  localparam logic [1:0] LIVES0 = 2'(START_LIVES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_lives;
  logic [1:0]  w_lives_nxt;
  logic [7:0]  r_time;
  logic [7:0]  w_time_nxt;
  logic [15:0] r_frame;
  logic [15:0] w_frame_nxt;
  logic [15:0] r_phase;
  logic [15:0] w_phase_nxt;
  logic        r_play_en;
  logic        r_bonus;
  logic        w_bonus_nxt;
  logic        r_grst;
  logic        w_grst_nxt;
  logic        r_hrst;
  logic        w_hrst_nxt;

  // Level time: subtract with saturation at 0, then
  // apply the floor; all in 9 bits so nothing wraps.
  logic [8:0] w_step;
  logic [8:0] w_sub;
  logic [8:0] w_lvl9;
  logic [7:0] w_lvl_time;

  assign w_step = TS9 * {5'd0, level};
  assign w_sub  = (w_step >= LT9) ? 9'd0 : LT9 - w_step;
  assign w_lvl9 = (w_sub < MT9) ? MT9 : w_sub;
  assign w_lvl_time = w_lvl9[8] ? 8'hFF : w_lvl9[7:0];

  // One timer second elapses on this tick.
  logic w_sec;
  assign w_sec = frame_tick && (r_frame == FPS_M1);

  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_time_nxt  = r_time;
    w_frame_nxt = r_frame;
    w_phase_nxt = r_phase;
    w_bonus_nxt = 1'b0;
    w_grst_nxt  = 1'b0;
    w_hrst_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_READY;
          w_grst_nxt  = 1'b1;
          w_hrst_nxt  = 1'b1;
          w_lives_nxt = LIVES0;
          w_time_nxt  = w_lvl_time;
          w_phase_nxt = 16'd0;
        end
      end

      S_READY: begin
        if (frame_tick) begin
          if (r_phase == RDY_M1) begin
            w_state_nxt = S_PLAY;
            w_frame_nxt = 16'd0;
          end else begin
            w_phase_nxt = r_phase + 16'd1;
          end
        end
      end

      S_PLAY: begin
        if (frame_tick) begin
          w_frame_nxt = w_sec ? 16'd0 : r_frame + 16'd1;
        end
        if (w_sec && r_time != 8'd0) begin
          w_time_nxt = r_time - 8'd1;
        end
        // Goal beats death, even on the final second.
        if (level_done) begin
          w_state_nxt = S_CLEAR;
          w_phase_nxt = 16'd0;
        end else if (hero_caught ||
                     (w_sec && r_time == 8'd1)) begin
          w_state_nxt = S_DYING;
          w_phase_nxt = 16'd0;
          if (r_lives != 2'd0) begin
            w_lives_nxt = r_lives - 2'd1;
          end
        end
      end

      S_CLEAR: begin
        if (frame_tick) begin
          if (r_time != 8'd0) begin
            w_bonus_nxt = 1'b1;
            w_time_nxt  = r_time - 8'd1;
          end else begin
            // level has advanced by now: load its time
            w_state_nxt = S_READY;
            w_hrst_nxt  = 1'b1;
            w_time_nxt  = w_lvl_time;
            w_phase_nxt = 16'd0;
          end
        end
      end

      S_DYING: begin
        if (frame_tick) begin
          if (r_phase == DTH_M1) begin
            w_phase_nxt = 16'd0;
            if (r_lives == 2'd0) begin
              w_state_nxt = S_OVER;
            end else begin
              w_state_nxt = S_READY;
              w_hrst_nxt  = 1'b1;
              w_time_nxt  = w_lvl_time;
            end
          end else begin
            w_phase_nxt = r_phase + 16'd1;
          end
        end
      end

      S_OVER: begin
        if (frame_tick) begin
          if (r_phase == OVR_M1) begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = 16'd0;
          end else begin
            w_phase_nxt = r_phase + 16'd1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lives   <= LIVES0;
      r_time    <= 8'd0;
      r_frame   <= 16'd0;
      r_phase   <= 16'd0;
      r_play_en <= 1'b0;
      r_bonus   <= 1'b0;
      r_grst    <= 1'b0;
      r_hrst    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lives   <= w_lives_nxt;
      r_time    <= w_time_nxt;
      r_frame   <= w_frame_nxt;
      r_phase   <= w_phase_nxt;
      r_play_en <= (w_state_nxt == S_PLAY);
      r_bonus   <= w_bonus_nxt;
      r_grst    <= w_grst_nxt;
      r_hrst    <= w_hrst_nxt;
    end
  end

  assign game_state   = r_state;
  assign play_en      = r_play_en;
  assign lives        = r_lives;
  assign time_left    = r_time;
  assign bonus_valid  = r_bonus;
  assign bonus_value  = 16'(BONUS_PER_SEC);
  assign game_rst     = r_grst;
  assign hero_rst_req = r_hrst;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed scenarios plus random
// stimulus checked against a rule-level model of the game flow.

module tb_game_flow_controller;

  localparam int FPS = 2;
  localparam int LT  = 10;
  localparam int TS  = 4;
  localparam int MT  = 3;
  localparam int RF  = 3;
  localparam int DF  = 2;
  localparam int OF  = 2;
  localparam int SL  = 3;
  localparam int BPS = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  level = 4'd0;
  logic        level_done = 1'b0;
  logic        hero_caught = 1'b0;
  logic [2:0]  game_state;
  logic        play_en;
  logic [1:0]  lives;
  logic [7:0]  time_left;
  logic        bonus_valid;
  logic [15:0] bonus_value;
  logic        game_rst;
  logic        hero_rst_req;

  int n_checks = 0;
  int n_fail   = 0;

  game_flow_controller #(
    .FRAMES_PER_SEC(FPS),
    .LEVEL_TIME(LT),
    .TIME_STEP(TS),
    .MIN_TIME(MT),
    .READY_FRAMES(RF),
    .DEATH_FRAMES(DF),
    .OVER_FRAMES(OF),
    .START_LIVES(SL),
    .BONUS_PER_SEC(BPS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .start(start),
    .level(level),
    .level_done(level_done),
    .hero_caught(hero_caught),
    .game_state(game_state),
    .play_en(play_en),
    .lives(lives),
    .time_left(time_left),
    .bonus_valid(bonus_valid),
    .bonus_value(bonus_value),
    .game_rst(game_rst),
    .hero_rst_req(hero_rst_req)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0..5 names the screen the game is on.
  int m_mode, m_lives, m_time, m_sub, m_ph;
  bit m_bv, m_gr, m_hr;

  function automatic int lvl_secs(input int lv);
    int t;
    t = LT - TS * lv;
    if (t < MT) t = MT;
    return t;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_lives = SL; m_time = 0;
    m_sub = 0; m_ph = 0;
    m_bv = 0; m_gr = 0; m_hr = 0;
  endtask

  task automatic model_step(input bit st, ft, ld, hc,
                            input int lv);
    bit sec;
    m_bv = 0; m_gr = 0; m_hr = 0;
    sec = 0;
    case (m_mode)
      0: if (st) begin
        m_mode = 1; m_gr = 1; m_hr = 1; m_lives = SL;
        m_time = lvl_secs(lv); m_ph = 0;
      end
      1: if (ft) begin
        m_ph++;
        if (m_ph == RF) begin m_mode = 2; m_sub = 0; end
      end
      2: begin
        if (ft) begin
          m_sub++;
          if (m_sub == FPS) begin
            m_sub = 0; sec = 1;
            if (m_time > 0) m_time--;
          end
        end
        if (ld) begin
          m_mode = 3; m_ph = 0;
        end else if (hc || (sec && m_time == 0)) begin
          m_mode = 4; m_ph = 0;
          if (m_lives > 0) m_lives--;
        end
      end
      3: if (ft) begin
        if (m_time > 0) begin
          m_bv = 1; m_time--;
        end else begin
          m_hr = 1; m_mode = 1;
          m_time = lvl_secs(lv); m_ph = 0;
        end
      end
      4: if (ft) begin
        m_ph++;
        if (m_ph == DF) begin
          m_ph = 0;
          if (m_lives == 0) m_mode = 5;
          else begin
            m_mode = 1; m_hr = 1; m_time = lvl_secs(lv);
          end
        end
      end
      5: if (ft) begin
        m_ph++;
        if (m_ph == OF) begin m_mode = 0; m_ph = 0; end
      end
      default: m_mode = 0;
    endcase
  endtask

  function automatic logic [16:0] exp_vec();
    return {3'(m_mode), m_mode == 2, 2'(m_lives),
            8'(m_time), m_bv, m_gr, m_hr};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {game_state, play_en, lives, time_left,
            bonus_valid, game_rst, hero_rst_req};
  endfunction

  task automatic cyc(input bit st, ft, ld, hc);
    start = st; frame_tick = ft;
    level_done = ld; hero_caught = hc;
    @(posedge clk);
    model_step(st, ft, ld, hc, int'(level));
    #1;
    start = 0; frame_tick = 0;
    level_done = 0; hero_caught = 0;
  endtask

  task automatic tick();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    m_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (game_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", game_state);
    end
    n_checks++;
    if (lives !== 2'd3 || time_left !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_regs: lives %0d time %0d want 3 0",
               lives, time_left);
    end
    n_checks++;
    if ({play_en, bonus_valid, game_rst, hero_rst_req} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b want 0000",
               {play_en, bonus_valid, game_rst, hero_rst_req});
    end
    n_checks++;
    if (bonus_value !== 16'd10) begin
      n_fail++;
      $display("FAIL bonus_value: got %0d want 10", bonus_value);
    end
    rst = 1'b0;
    cyc(0, 1, 0, 0);
    n_checks++;
    if (game_state !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_tick: got %0d want 0", game_state);
    end
  endtask

  task automatic test_start_timeout();
    level = 4'd0;
    cyc(1, 0, 0, 0);
    n_checks++;
    if ({game_rst, hero_rst_req} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_pulses: got %b want 11",
               {game_rst, hero_rst_req});
    end
    n_checks++;
    if ({game_state, time_left, lives} !== {3'd1, 8'd10, 2'd3}) begin
      n_fail++;
      $display("FAIL start_ready: st %0d time %0d lives %0d want 1 10 3",
               game_state, time_left, lives);
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if ({game_rst, hero_rst_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL start_once: got %b want 00",
               {game_rst, hero_rst_req});
    end
    tick(); tick();
    n_checks++;
    if (game_state !== 3'd1) begin
      n_fail++;
      $display("FAIL ready_hold: got %0d want 1", game_state);
    end
    tick();
    n_checks++;
    if (game_state !== 3'd2 || play_en !== 1'b1) begin
      n_fail++;
      $display("FAIL to_play: st %0d en %b want 2 1",
               game_state, play_en);
    end
    tick(); tick();
    n_checks++;
    if (time_left !== 8'd9) begin
      n_fail++;
      $display("FAIL first_sec: got %0d want 9", time_left);
    end
    repeat (17) tick();
    n_checks++;
    if (game_state !== 3'd2 || time_left !== 8'd1) begin
      n_fail++;
      $display("FAIL pre_timeout: st %0d time %0d want 2 1",
               game_state, time_left);
    end
    tick();
    n_checks++;
    if ({game_state, lives, play_en} !== {3'd4, 2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout: st %0d lives %0d en %b want 4 2 0",
               game_state, lives, play_en);
    end
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    n_checks++;
    if ({game_state, hero_rst_req, time_left} !==
        {3'd1, 1'b1, 8'd10}) begin
      n_fail++;
      $display("FAIL respawn: st %0d hr %b time %0d want 1 1 10",
               game_state, hero_rst_req, time_left);
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL timeout_model: got %h want %h",
               dut_vec(), exp_vec());
    end
  endtask

  task automatic test_clear();
    int nb;
    nb = 0;
    repeat (3) tick();
    repeat (12) tick();
    n_checks++;
    if (time_left !== 8'd4) begin
      n_fail++;
      $display("FAIL clear_pre: got %0d want 4", time_left);
    end
    cyc(0, 0, 1, 0);
    n_checks++;
    if ({game_state, time_left, lives} !== {3'd3, 8'd4, 2'd2}) begin
      n_fail++;
      $display("FAIL clear_enter: st %0d time %0d lives %0d want 3 4 2",
               game_state, time_left, lives);
    end
    level = 4'd1;
    repeat (4) begin
      cyc(0, 1, 0, 0);
      if (bonus_valid === 1'b1) nb++;
      n_checks++;
      if (bonus_valid !== 1'b1 || bonus_value !== 16'd10) begin
        n_fail++;
        $display("FAIL bonus_pulse: v %b val %0d want 1 10",
                 bonus_valid, bonus_value);
      end
      cyc(0, 0, 0, 0);
      if (bonus_valid === 1'b1) nb++;
    end
    n_checks++;
    if (nb !== 4) begin
      n_fail++;
      $display("FAIL bonus_count: got %0d want 4", nb);
    end
    cyc(0, 1, 0, 0);
    n_checks++;
    if ({game_state, hero_rst_req, time_left, bonus_valid} !==
        {3'd1, 1'b1, 8'd6, 1'b0}) begin
      n_fail++;
      $display("FAIL clear_exit: st %0d hr %b time %0d bv %b want 1 1 6 0",
               game_state, hero_rst_req, time_left, bonus_valid);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_min_floor();
    level = 4'd3;
    repeat (3) tick();
    cyc(0, 0, 1, 0);
    repeat (6) tick();
    cyc(0, 1, 0, 0);
    n_checks++;
    if (game_state !== 3'd1 || time_left !== 8'd3) begin
      n_fail++;
      $display("FAIL min_floor: st %0d time %0d want 1 3",
               game_state, time_left);
    end
    cyc(0, 0, 0, 0);
    level = 4'd0;
  endtask

  task automatic test_mid_reset();
    repeat (3) tick();
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dut_vec() !== {3'd0, 1'b0, 2'd3, 8'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL async_rst: got %h want %h", dut_vec(),
               {3'd0, 1'b0, 2'd3, 8'd0, 3'b000});
    end
    @(posedge clk);
    #1;
    m_reset();
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== {3'd0, 1'b0, 2'd3, 8'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL post_rst: got %h want %h", dut_vec(),
               {3'd0, 1'b0, 2'd3, 8'd0, 3'b000});
    end
  endtask

  task automatic test_game_over();
    level = 4'd0;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      repeat (3) tick();
      cyc(0, 0, 0, 1);
      n_checks++;
      if (game_state !== 3'd4 || lives !== 2'(2 - k)) begin
        n_fail++;
        $display("FAIL caught%0d: st %0d lives %0d want 4 %0d",
                 k, game_state, lives, 2 - k);
      end
      if (k < 2) repeat (2) tick();
    end
    tick();
    cyc(0, 1, 0, 0);
    n_checks++;
    if (game_state !== 3'd5 || hero_rst_req !== 1'b0) begin
      n_fail++;
      $display("FAIL to_over: st %0d hr %b want 5 0",
               game_state, hero_rst_req);
    end
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    n_checks++;
    if (game_state !== 3'd5 || game_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL over_start: st %0d grst %b want 5 0",
               game_state, game_rst);
    end
    cyc(0, 1, 0, 0);
    n_checks++;
    if (game_state !== 3'd0 || lives !== 2'd0) begin
      n_fail++;
      $display("FAIL to_idle: st %0d lives %0d want 0 0",
               game_state, lives);
    end
  endtask

  task automatic test_simultaneous();
    level = 4'd0;
    cyc(1, 0, 0, 0);
    repeat (3) tick();
    cyc(0, 0, 1, 1);
    n_checks++;
    if (game_state !== 3'd3 || lives !== 2'd3) begin
      n_fail++;
      $display("FAIL sim_ld_hc: st %0d lives %0d want 3 3",
               game_state, lives);
    end
    repeat (10) tick();
    tick();
    repeat (3) tick();
    repeat (18) tick();
    tick();
    cyc(0, 1, 1, 0);
    n_checks++;
    if ({game_state, time_left, lives} !== {3'd3, 8'd0, 2'd3}) begin
      n_fail++;
      $display("FAIL sim_ld_last: st %0d time %0d lives %0d want 3 0 3",
               game_state, time_left, lives);
    end
    cyc(0, 1, 0, 0);
    n_checks++;
    if ({game_state, hero_rst_req, time_left} !==
        {3'd1, 1'b1, 8'd10}) begin
      n_fail++;
      $display("FAIL sim_exit: st %0d hr %b time %0d want 1 1 10",
               game_state, hero_rst_req, time_left);
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL sim_model: got %h want %h",
               dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit st, ft, ld, hc;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 31) == 0) level = 4'($urandom_range(0, 15));
      st = ($urandom_range(0, 7) == 0);
      ft = ($urandom_range(0, 1) == 0);
      ld = ($urandom_range(0, 15) == 0);
      hc = ($urandom_range(0, 19) == 0);
      cyc(st, ft, ld, hc);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random@%0d: got %h want %h",
                 i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_timeout();
    test_clear();
    test_min_floor();
    test_mid_reset();
    test_game_over();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
